// File: rtl/rv32_mem_arbiter.sv
// Arbitrates one single-port memory between rv32 fetch and load/store ports.
// Data has priority, bounded by a fetch-starvation limit; each access has an ack timeout.
module rv32_mem_arbiter #(
  parameter int TIMEOUT      = 16,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ready,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_ready,
  output logic        m_req,
  output logic        m_we,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic [31:0] m_rdata,
  input  logic        m_ack,
  output logic        busy,
  output logic        err
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, DONE} state_t;

  state_t      state, state_n;
  logic [TW-1:0] tcnt;
  logic [SW-1:0] starve;
  logic        sel_d;
  logic        tout;
  logic        m_we_q;
  logic [31:0] m_addr_q, m_wdata_q, if_rdata_q, d_rdata_q;
  logic        grant_d, grant_i, acked, expired;
  logic [31:0] cap_data;

  always_comb begin
    state_n = state;
    grant_d = 1'b0;
    grant_i = 1'b0;
    acked   = 1'b0;
    expired = 1'b0;
    case (state)
      IDLE: begin
        if (d_req && (!if_req || (starve < SW'(STARVE_LIMIT)))) begin
          grant_d = 1'b1;
          state_n = BUSY_D;
        end else if (if_req) begin
          grant_i = 1'b1;
          state_n = BUSY_I;
        end
      end
      BUSY_I, BUSY_D: begin
        // An ack arriving in the final allowed cycle still wins over the timeout.
        if (m_ack) begin
          acked   = 1'b1;
          state_n = DONE;
        end else if (tcnt == TW'(TIMEOUT - 1)) begin
          expired = 1'b1;
          state_n = DONE;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Stores and timed-out accesses return zero.
  assign cap_data = (acked && !m_we_q) ? m_rdata : 32'h0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      tcnt       <= '0;
      starve     <= '0;
      sel_d      <= 1'b0;
      tout       <= 1'b0;
      m_we_q     <= 1'b0;
      m_addr_q   <= '0;
      m_wdata_q  <= '0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      state <= state_n;
      if (grant_d || grant_i) begin
        m_addr_q  <= grant_d ? d_addr : if_addr;
        m_we_q    <= grant_d & d_we;
        m_wdata_q <= grant_d ? d_wdata : 32'h0;
        sel_d     <= grant_d;
        tout      <= 1'b0;
        tcnt      <= '0;
      end
      if (grant_d) begin
        if (!if_req)
          starve <= '0;
        else if (starve != SW'(STARVE_LIMIT))
          starve <= starve + 1'b1;
      end
      if (grant_i)
        starve <= '0;
      if ((state == BUSY_I || state == BUSY_D) && state_n != DONE)
        tcnt <= tcnt + 1'b1;
      if (state == DONE)
        tcnt <= '0;
      if (acked || expired) begin
        tout <= expired;
        if (sel_d) d_rdata_q  <= cap_data;
        else       if_rdata_q <= cap_data;
      end
    end
  end

  assign busy     = (state != IDLE);
  assign m_req    = (state == BUSY_I) || (state == BUSY_D);
  assign m_we     = m_we_q;
  assign m_addr   = m_addr_q;
  assign m_wdata  = m_wdata_q;
  assign if_ready = (state == DONE) && !sel_d;
  assign d_ready  = (state == DONE) && sel_d;
  assign err      = (state == DONE) && tout;
  assign if_rdata = if_rdata_q;
  assign d_rdata  = d_rdata_q;

endmodule

// File: tb/tb_rv32_mem_arbiter.sv
// Directed bench for rv32_mem_arbiter with TIMEOUT=16 and STARVE_LIMIT=4.
module tb_rv32_mem_arbiter;

  logic        clk, reset;
  logic        if_req, if_ready;
  logic [31:0] if_addr, if_rdata;
  logic        d_req, d_we, d_ready;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic        m_req, m_we, m_ack, busy, err;
  logic [31:0] m_addr, m_wdata, m_rdata;

  int errors = 0;
  int checks = 0;

  rv32_mem_arbiter #(.TIMEOUT(16), .STARVE_LIMIT(4)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ready(d_ready),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_ack(m_ack), .busy(busy), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cyc();
    cyc();
    checks++;
    if ({m_req, busy, if_ready, d_ready, err, m_we} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b want 000000", {m_req, busy, if_ready, d_ready, err, m_we});
    end
    checks++;
    if ({m_addr, m_wdata, if_rdata, d_rdata} !== 128'h0) begin
      errors++;
      $display("FAIL reset_data: got %h %h %h %h want zeros", m_addr, m_wdata, if_rdata, d_rdata);
    end
    reset = 1'b0;
    cyc();
  endtask

  task automatic test_single_fetch();
    if_req = 1'b1; if_addr = 32'h100;
    cyc();
    checks++;
    if ({m_req, busy, m_we, if_ready} !== 4'b1100 || m_addr !== 32'h100) begin
      errors++;
      $display("FAIL fetch_busy: got req/busy/we/rdy=%b addr=%h want 1100 addr=00000100", {m_req, busy, m_we, if_ready}, m_addr);
    end
    m_ack = 1'b1; m_rdata = 32'h00500093;
    cyc();
    checks++;
    if ({m_req, busy, if_ready, d_ready, err} !== 5'b01100 || if_rdata !== 32'h00500093) begin
      errors++;
      $display("FAIL fetch_done: got req/busy/ird/drd/err=%b rdata=%h want 01100 rdata=00500093", {m_req, busy, if_ready, d_ready, err}, if_rdata);
    end
    m_ack = 1'b0; if_req = 1'b0;
    cyc();
    checks++;
    if ({m_req, busy, if_ready} !== 3'b000) begin
      errors++;
      $display("FAIL fetch_idle: got %b want 000", {m_req, busy, if_ready});
    end
  endtask

  task automatic test_simultaneous();
    if_req = 1'b1; if_addr = 32'h104;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h2000; d_wdata = 32'hDEADBEEF;
    cyc();
    checks++;
    if (m_req !== 1'b1 || m_we !== 1'b1 || m_addr !== 32'h2000 || m_wdata !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL sim_store_grant: got req=%b we=%b addr=%h wdata=%h want 1 1 00002000 deadbeef", m_req, m_we, m_addr, m_wdata);
    end
    m_ack = 1'b1; m_rdata = 32'hFFFFFFFF;
    cyc();
    checks++;
    if (d_ready !== 1'b1 || if_ready !== 1'b0 || d_rdata !== 32'h0 || err !== 1'b0) begin
      errors++;
      $display("FAIL sim_store_done: got drd=%b ird=%b rdata=%h err=%b want 1 0 00000000 0", d_ready, if_ready, d_rdata, err);
    end
    m_ack = 1'b0; d_req = 1'b0; d_we = 1'b0;
    cyc();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL sim_idle: got busy=%b want 0", busy);
    end
    cyc();
    checks++;
    if (m_req !== 1'b1 || m_we !== 1'b0 || m_addr !== 32'h104) begin
      errors++;
      $display("FAIL sim_fetch_grant: got req=%b we=%b addr=%h want 1 0 00000104", m_req, m_we, m_addr);
    end
    m_ack = 1'b1; m_rdata = 32'h00000013;
    cyc();
    checks++;
    if (if_ready !== 1'b1 || if_rdata !== 32'h13) begin
      errors++;
      $display("FAIL sim_fetch_done: got rdy=%b rdata=%h want 1 00000013", if_ready, if_rdata);
    end
    m_ack = 1'b0; if_req = 1'b0;
    cyc();
  endtask

  task automatic test_starvation();
    logic exp_d [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    logic is_d;
    if_req = 1'b1; if_addr = 32'h200;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h3000;
    for (int n = 0; n < 6; n++) begin
      cyc();
      is_d = (m_addr == 32'h3000);
      checks++;
      if (m_req !== 1'b1 || is_d !== exp_d[n]) begin
        errors++;
        $display("FAIL starve_grant%0d: got req=%b data=%b want 1 %b", n, m_req, is_d, exp_d[n]);
      end
      m_ack = 1'b1; m_rdata = 32'h1000 + n;
      cyc();
      checks++;
      if (d_ready !== exp_d[n] || if_ready !== !exp_d[n]) begin
        errors++;
        $display("FAIL starve_ready%0d: got drd=%b ird=%b want %b %b", n, d_ready, if_ready, exp_d[n], !exp_d[n]);
      end
      m_ack = 1'b0;
      cyc();
    end
    checks++;
    if (if_rdata !== 32'h1004 || d_rdata !== 32'h1005) begin
      errors++;
      $display("FAIL starve_rdata: got if=%h d=%h want 00001004 00001005", if_rdata, d_rdata);
    end
    if_req = 1'b0; d_req = 1'b0;
    cyc();
  endtask

  task automatic test_timeout();
    int n;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h4000; m_rdata = 32'hAAAAAAAA;
    cyc();
    n = 0;
    while (m_req === 1'b1 && n < 40) begin
      n++;
      cyc();
    end
    checks++;
    if (n !== 16) begin
      errors++;
      $display("FAIL tout_len: got %0d cycles of m_req want 16", n);
    end
    checks++;
    if (d_ready !== 1'b1 || err !== 1'b1 || d_rdata !== 32'h0 || if_ready !== 1'b0) begin
      errors++;
      $display("FAIL tout_done: got drd=%b err=%b rdata=%h ird=%b want 1 1 00000000 0", d_ready, err, d_rdata, if_ready);
    end
    d_req = 1'b0;
    cyc();
    checks++;
    if (err !== 1'b0 || busy !== 1'b0 || d_ready !== 1'b0) begin
      errors++;
      $display("FAIL tout_after: got err=%b busy=%b drd=%b want 0 0 0", err, busy, d_ready);
    end
    cyc();
    m_ack = 1'b1; m_rdata = 32'h55555555;
    cyc();
    m_ack = 1'b0;
    checks++;
    if ({busy, m_req, d_ready, if_ready, err} !== 5'b0 || d_rdata !== 32'h0) begin
      errors++;
      $display("FAIL late_ack: got busy/req/drd/ird/err=%b rdata=%h want 00000 00000000", {busy, m_req, d_ready, if_ready, err}, d_rdata);
    end
    cyc();
  endtask

  task automatic test_wait_states();
    logic early;
    early = 1'b0;
    if_req = 1'b1; if_addr = 32'h500;
    cyc();
    for (int j = 1; j <= 6; j++) begin
      if (if_ready !== 1'b0 || m_req !== 1'b1) early = 1'b1;
      m_ack = (j == 6); m_rdata = (j == 6) ? 32'h12345678 : 32'h0;
      cyc();
    end
    checks++;
    if (early !== 1'b0) begin
      errors++;
      $display("FAIL ws_early: got early ready/missing m_req=%b want 0", early);
    end
    checks++;
    if (if_ready !== 1'b1 || if_rdata !== 32'h12345678 || err !== 1'b0) begin
      errors++;
      $display("FAIL ws_done: got rdy=%b rdata=%h err=%b want 1 12345678 0", if_ready, if_rdata, err);
    end
    m_ack = 1'b0; if_req = 1'b0;
    cyc();
    early = 1'b0;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h600;
    cyc();
    for (int j = 1; j <= 16; j++) begin
      if (m_req !== 1'b1 || d_ready !== 1'b0) early = 1'b1;
      m_ack = (j == 16); m_rdata = 32'hCAFEF00D;
      cyc();
    end
    checks++;
    if (early !== 1'b0) begin
      errors++;
      $display("FAIL ack16_busy: got early end=%b want 0", early);
    end
    checks++;
    if (d_ready !== 1'b1 || err !== 1'b0 || d_rdata !== 32'hCAFEF00D) begin
      errors++;
      $display("FAIL ack16_done: got drd=%b err=%b rdata=%h want 1 0 cafef00d", d_ready, err, d_rdata);
    end
    m_ack = 1'b0; d_req = 1'b0;
    cyc();
  endtask

  task automatic test_reset_mid();
    logic exp_d [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic is_d;
    logic stray;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h700;
    if_req = 1'b1; if_addr = 32'h800;
    cyc();
    checks++;
    if (m_req !== 1'b1 || m_addr !== 32'h700) begin
      errors++;
      $display("FAIL rst_grant: got req=%b addr=%h want 1 00000700", m_req, m_addr);
    end
    cyc();
    reset = 1'b1;
    cyc();
    checks++;
    if ({m_req, busy, d_ready, if_ready, err} !== 5'b0) begin
      errors++;
      $display("FAIL rst_abort: got req/busy/drd/ird/err=%b want 00000", {m_req, busy, d_ready, if_ready, err});
    end
    reset = 1'b0;
    stray = 1'b0;
    for (int n = 0; n < 5; n++) begin
      cyc();
      is_d = (m_addr == 32'h700);
      checks++;
      if (m_req !== 1'b1 || is_d !== exp_d[n]) begin
        errors++;
        $display("FAIL rst_starve%0d: got req=%b data=%b want 1 %b", n, m_req, is_d, exp_d[n]);
      end
      m_ack = 1'b1; m_rdata = 32'h2000 + n;
      cyc();
      if (d_ready !== exp_d[n] || if_ready !== !exp_d[n] || err !== 1'b0) stray = 1'b1;
      m_ack = 1'b0;
      cyc();
    end
    checks++;
    if (stray !== 1'b0 || if_rdata !== 32'h2004) begin
      errors++;
      $display("FAIL rst_fetch: got bad_ready=%b rdata=%h want 0 00002004", stray, if_rdata);
    end
    d_req = 1'b0; if_req = 1'b0;
    cyc();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    if_req = 1'b0; if_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    m_rdata = '0; m_ack = 1'b0;
    test_reset();
    test_single_fetch();
    test_simultaneous();
    test_starvation();
    test_timeout();
    test_wait_states();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
